// File: rtl/sprite_renderer.sv
// Palette-indexed sprite overlay on a raster scan, pixel_out/hit_out L=2+ROM_LAT+PAL_LAT cycles after raster sample.
// Free-running, no backpressure; SPRITE_MIRROR_EN adds mirror_in for horizontal flip.
module sprite_renderer #(
  parameter int         WIDTH           = 32,
  parameter int         HEIGHT          = 32,
  parameter int         SCALE_LOG2      = 0,
  parameter logic [7:0] TRANSPARENT_IDX = 8'h00,
  parameter int         ROM_LAT         = 2,
  parameter int         PAL_LAT         = 2
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  input  logic [9:0]                        hcount_in,
  input  logic [8:0]                        vcount_in,
  input  logic [9:0]                        x_in,
  input  logic [8:0]                        y_in,
  input  logic                              pos_valid_in,
`ifdef SPRITE_MIRROR_EN
  input  logic                              mirror_in,
`endif
  input  logic                              enable_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   rom_addr_out,
  input  logic [7:0]                        rom_data_in,
  output logic [7:0]                        pal_addr_out,
  input  logic [11:0]                       pal_rgb_in,
  output logic [11:0]                       pixel_out,
  output logic                              hit_out,
  output logic                              pos_pending_out
);

  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int L  = 2 + ROM_LAT + PAL_LAT;
  localparam int DL = L - 1;

  logic [9:0]    act_x, pend_x;
  logic [8:0]    act_y, pend_y;
  logic          frame_start;
  logic [10:0]   x_end;
  logic [9:0]    y_end;
  logic          in_fp;
  logic [9:0]    dx;
  logic [8:0]    dy;
  logic [AW-1:0] col, row, addr_next;
  logic [DL-1:0] fp_dl, en_dl;
  logic [7:0]    idx_d;
  logic          hit_next;
`ifdef SPRITE_MIRROR_EN
  logic          act_mirror, pend_mirror;
`endif

  assign frame_start = (hcount_in == 10'd0) && (vcount_in == 9'd0);

  // Position only moves at frame start so a sprite is never split across two positions.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      act_x           <= '0;
      act_y           <= '0;
      pend_x          <= '0;
      pend_y          <= '0;
      pos_pending_out <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      act_mirror      <= 1'b0;
      pend_mirror     <= 1'b0;
`endif
    end else if (frame_start) begin
      if (pos_valid_in) begin
        act_x <= x_in;
        act_y <= y_in;
`ifdef SPRITE_MIRROR_EN
        act_mirror <= mirror_in;
`endif
      end else if (pos_pending_out) begin
        act_x <= pend_x;
        act_y <= pend_y;
`ifdef SPRITE_MIRROR_EN
        act_mirror <= pend_mirror;
`endif
      end
      pos_pending_out <= 1'b0;
    end else if (pos_valid_in) begin
      pend_x          <= x_in;
      pend_y          <= y_in;
      pos_pending_out <= 1'b1;
`ifdef SPRITE_MIRROR_EN
      pend_mirror     <= mirror_in;
`endif
    end
  end

  // Widened compares keep the footprint from wrapping past the raster edge.
  always_comb begin
    x_end = {1'b0, act_x} + 11'(WIDTH << SCALE_LOG2);
    y_end = {1'b0, act_y} + 10'(HEIGHT << SCALE_LOG2);
    in_fp = (hcount_in >= act_x) && ({1'b0, hcount_in} < x_end) &&
            (vcount_in >= act_y) && ({1'b0, vcount_in} < y_end);
    dx    = hcount_in - act_x;
    dy    = vcount_in - act_y;
    col   = AW'(dx >> SCALE_LOG2);
    row   = AW'(dy >> SCALE_LOG2);
`ifdef SPRITE_MIRROR_EN
    if (act_mirror) col = AW'(WIDTH - 1) - col;
`endif
    addr_next = row * AW'(WIDTH) + col;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rom_addr_out <= '0;
      fp_dl        <= '0;
      en_dl        <= '0;
    end else begin
      rom_addr_out <= in_fp ? addr_next : '0;
      fp_dl[0]     <= in_fp;
      en_dl[0]     <= enable_in;
      for (int i = 1; i < DL; i++) begin
        fp_dl[i] <= fp_dl[i-1];
        en_dl[i] <= en_dl[i-1];
      end
    end
  end

  assign pal_addr_out = rom_data_in;

  // Index is held back to line up with the palette colour it selected.
  generate
    if (PAL_LAT == 0) begin : g_idx_direct
      assign idx_d = rom_data_in;
    end else begin : g_idx_pipe
      logic [7:0] idx_dl [PAL_LAT];
      always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
          for (int i = 0; i < PAL_LAT; i++) idx_dl[i] <= '0;
        end else begin
          idx_dl[0] <= rom_data_in;
          for (int i = 1; i < PAL_LAT; i++) idx_dl[i] <= idx_dl[i-1];
        end
      end
      assign idx_d = idx_dl[PAL_LAT-1];
    end
  endgenerate

  assign hit_next = fp_dl[DL-1] && en_dl[DL-1] && (idx_d != TRANSPARENT_IDX);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hit_out   <= 1'b0;
      pixel_out <= '0;
    end else begin
      hit_out   <= hit_next;
      pixel_out <= hit_next ? pal_rgb_in : 12'h000;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: 4x2 sprite at scale 1x and 2x side by side, external ROMs with 2-cycle latency,
// directed cases then random raster traffic against a geometric reference model.
module tb_sprite_renderer;
  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst, pv, en, mir;
  logic [9:0] hc, xi;
  logic [8:0] vc, yi;

  logic [2:0]  ra  [2];
  logic [7:0]  rd  [2];
  logic [7:0]  pa  [2];
  logic [11:0] pr  [2];
  logic [11:0] pix [2];
  logic        hit [2];
  logic        pp  [2];

  logic [7:0]  rom_mem [8];
  logic [11:0] pal_mem [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0] a1 = '0, a2 = '0;
    logic [7:0] p1 = '0, p2 = '0;
    sprite_renderer #(.WIDTH(4), .HEIGHT(2), .SCALE_LOG2(g), .TRANSPARENT_IDX(8'h00),
                      .ROM_LAT(2), .PAL_LAT(2)) u_dut (
      .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
      .x_in(xi), .y_in(yi), .pos_valid_in(pv),
`ifdef SPRITE_MIRROR_EN
      .mirror_in(mir),
`endif
      .enable_in(en), .rom_addr_out(ra[g]), .rom_data_in(rd[g]),
      .pal_addr_out(pa[g]), .pal_rgb_in(pr[g]), .pixel_out(pix[g]),
      .hit_out(hit[g]), .pos_pending_out(pp[g]));
    always @(posedge clk) begin
      a1 <= ra[g];
      a2 <= a1;
      p1 <= pa[g];
      p2 <= p1;
    end
    assign rd[g] = rom_mem[a2];
    assign pr[g] = pal_mem[p2];
  end

  int checks = 0, failures = 0, cnt = 0;
  int m_ax, m_ay, m_px, m_py;
  bit m_am, m_pm, m_pend;
  bit ev [2][16];
  bit eh [2][16];
  logic [11:0] ep [2][16];
  int e_addr [2];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cnt);
    end
  endtask

  // Drive one raster sample, predict its effects, clock it, then compare.
  task automatic cyc(input int h, input int v);
    bit f, hexp;
    int col, row, addr, s;
    hc = 10'(h);
    vc = 9'(v);
    for (int d = 0; d < 2; d++) begin
      f = h >= m_ax && h < m_ax + (4 << d) && v >= m_ay && v < m_ay + (2 << d);
      col = (h - m_ax) >>> d;
      if (m_am) col = 3 - col;
      row = (v - m_ay) >>> d;
      addr = f ? row * 4 + col : 0;
      e_addr[d] = rst ? 0 : addr;
      hexp = !rst && f && en && rom_mem[addr] != 8'h00;
      s = (cnt + L) % 16;
      ev[d][s] = 1'b1;
      eh[d][s] = hexp;
      ep[d][s] = hexp ? pal_mem[rom_mem[addr]] : 12'h000;
      if (rst) begin
        for (int k = 1; k <= L; k++) begin
          ev[d][(cnt + k) % 16] = 1'b1;
          eh[d][(cnt + k) % 16] = 1'b0;
          ep[d][(cnt + k) % 16] = 12'h000;
        end
      end
    end
    if (rst) begin
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_am = 0; m_pm = 0; m_pend = 0;
    end else if (h == 0 && v == 0) begin
      if (pv) begin
        m_ax = int'(xi); m_ay = int'(yi); m_am = mir;
      end else if (m_pend) begin
        m_ax = m_px; m_ay = m_py; m_am = m_pm;
      end
      m_pend = 0;
    end else if (pv) begin
      m_px = int'(xi); m_py = int'(yi); m_pm = mir; m_pend = 1;
    end
    @(posedge clk);
    #1;
    cnt++;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rom_addr[s%0d]", d), int'(ra[d]), e_addr[d]);
      chk($sformatf("pos_pending[s%0d]", d), int'(pp[d]), int'(m_pend));
      if (ev[d][cnt % 16]) begin
        chk($sformatf("hit[s%0d]", d), int'(hit[d]), int'(eh[d][cnt % 16]));
        chk($sformatf("pixel[s%0d]", d), int'(pix[d]), int'(ep[d][cnt % 16]));
        ev[d][cnt % 16] = 1'b0;
      end
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1000, 500);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++) begin
        ev[d][s] = 1'b0; eh[d][s] = 1'b0; ep[d][s] = 12'h000;
      end
    for (int i = 0; i < 8; i++) rom_mem[i] = 8'(i + 1);
    rom_mem[6] = 8'h05;
    rom_mem[7] = 8'h00;
    for (int i = 0; i < 256; i++) pal_mem[i] = 12'($urandom);
    pal_mem[5] = 12'hF80;
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_am = 0; m_pm = 0; m_pend = 0;
    rst = 1; pv = 0; en = 1; mir = 0; xi = '0; yi = '0; hc = '0; vc = '0;

    cyc(1000, 500);
    cyc(1000, 500);
    rst = 0;
    chk("reset_pixel", int'(pix[0]), 0);
    chk("reset_hit", int'(hit[0]), 0);
    chk("reset_pending", int'(pp[0]), 0);

    // Position request mid-frame waits for frame start.
    pv = 1; xi = 10'd10; yi = 9'd5;
    cyc(50, 100);
    pv = 0;
    chk("pending_set", int'(pp[0]), 1);
    cyc(10, 5);
    flush(5);
    chk("no_hit_before_frame", int'(hit[0]), 0);
    chk("pending_held", int'(pp[0]), 1);
    cyc(0, 0);
    chk("pending_clear", int'(pp[0]), 0);
    cyc(10, 5);
    flush(5);
    chk("hit_next_frame", int'(hit[0]), 1);
    chk("hit_next_frame_x2", int'(hit[1]), 1);

    cyc(12, 6);
    chk("addr_12_6", int'(ra[0]), 6);
    flush(5);
    chk("pixel_12_6", int'(pix[0]), 12'hF80);
    chk("hit_12_6", int'(hit[0]), 1);

    cyc(13, 6);
    flush(5);
    chk("transparent_hit", int'(hit[0]), 0);
    chk("transparent_pixel", int'(pix[0]), 0);

    en = 0;
    cyc(12, 6);
    en = 1;
    flush(5);
    chk("disabled_hit", int'(hit[0]), 0);
    chk("disabled_pixel", int'(pix[0]), 0);

    cyc(10, 5);
    chk("x2_col_h10", int'(ra[1]), 0);
    cyc(11, 5);
    chk("x2_col_h11", int'(ra[1]), 0);
    cyc(17, 5);
    chk("x2_col_h17", int'(ra[1]), 3);
    cyc(18, 5);
    chk("x2_outside_h18", int'(ra[1]), 0);

    // Reset in the middle of the sprite.
    cyc(11, 5);
    rst = 1;
    cyc(12, 5);
    rst = 0;
    chk("midreset_pixel", int'(pix[0]), 0);
    chk("midreset_hit", int'(hit[0]), 0);
    cyc(1, 0);
    chk("midreset_origin_addr", int'(ra[0]), 1);

    // Right edge: no wrap onto the next line.
    pv = 1; xi = 10'd638; yi = 9'd5;
    cyc(300, 300);
    pv = 0;
    cyc(0, 0);
    cyc(638, 5);
    cyc(639, 5);
    cyc(0, 6);
    cyc(1, 6);
    flush(2);
    chk("edge_hit_638", int'(hit[0]), 1);
    flush(1);
    chk("edge_hit_639", int'(hit[0]), 1);
    flush(1);
    chk("edge_nowrap_0", int'(hit[0]), 0);
    flush(1);
    chk("edge_nowrap_1", int'(hit[0]), 0);

    pv = 1; xi = 10'd20; yi = 9'd30;
    cyc(0, 0);
    pv = 0;
    chk("direct_load_pending", int'(pp[0]), 0);
    cyc(21, 30);
    chk("direct_load_addr", int'(ra[0]), 1);

`ifdef SPRITE_MIRROR_EN
    pv = 1; xi = 10'd10; yi = 9'd5; mir = 1;
    cyc(5, 5);
    pv = 0; mir = 0;
    cyc(0, 0);
    cyc(12, 6);
    chk("mirror_addr", int'(ra[0]), 5);
`endif

    flush(L);
    for (int i = 0; i < 8; i++) rom_mem[i] = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 256; i++) pal_mem[i] = 12'($urandom);

    for (int i = 0; i < 400; i++) begin
      int h, v, r;
      rst = ($urandom % 150) == 0;
      en  = ($urandom % 8) != 0;
      pv  = ($urandom % 40) == 0;
      xi  = 10'($urandom_range(0, 639));
      yi  = 9'($urandom_range(0, 479));
`ifdef SPRITE_MIRROR_EN
      mir = 1'($urandom);
`endif
      r = $urandom % 30;
      if (r == 0) begin
        h = 0; v = 0;
      end else if (r == 1) begin
        h = $urandom_range(0, 1023); v = $urandom_range(0, 511);
      end else begin
        h = m_ax + $urandom_range(0, 11); v = m_ay + $urandom_range(0, 5);
      end
      cyc(h, v);
    end
    rst = 0; pv = 0;
    flush(L);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sprite width in source pixels.
REQ-002 SHALL have parameter HEIGHT, default 32: sprite height in source pixels.
REQ-003 SHALL have parameter SCALE_LOG2, default 0 (legal 0..2): on-screen replication factor 2^SCALE_LOG2 in both axes.
REQ-004 SHALL have parameter TRANSPARENT_IDX, default 8'h00: palette index treated as transparent.
REQ-005 SHALL have parameters ROM_LAT, default 2, and PAL_LAT, default 2: read latencies of external image ROM and palette ROM.
REQ-006 SHALL have port pixel_clk_in, input, 1: the only clock.
REQ-007 SHALL have port rst_in, input, 1: synchronous active-high reset.
REQ-008 SHALL have ports hcount_in (input, 10) and vcount_in (input, 9): current raster position.
REQ-009 SHALL have ports x_in (input, 10), y_in (input, 9), pos_valid_in (input, 1): requested top-left position, captured when pos_valid_in=1.
REQ-010 SHALL have port enable_in, input, 1: sprite visible when 1.
REQ-011 SHALL have ports rom_addr_out (output, $clog2(WIDTH*HEIGHT)) and rom_data_in (input, 8): image ROM read.
REQ-012 SHALL have ports pal_addr_out (output, 8) and pal_rgb_in (input, 12): palette ROM read, RGB444.
REQ-013 SHALL have ports pixel_out (output, 12), hit_out (output, 1), pos_pending_out (output, 1).

Function
REQ-014 Footprint SHALL be hcount_in in [xa, xa+(WIDTH<<SCALE_LOG2)) and vcount_in in [ya, ya+(HEIGHT<<SCALE_LOG2)), xa/ya = active position; compares in 11/10 bits, no wrap past 639/479.
REQ-015 In footprint: col=(hcount_in-xa)>>SCALE_LOG2, row=(vcount_in-ya)>>SCALE_LOG2; rom_addr_out SHALL be registered row*WIDTH+col one cycle after sampling; outside footprint rom_addr_out SHALL hold 0.
REQ-016 pal_addr_out SHALL equal rom_data_in combinationally.
REQ-017 pixel_out/hit_out SHALL be registered, latency L=2+ROM_LAT+PAL_LAT cycles from hcount_in/vcount_in sample.
REQ-018 Footprint flag and enable_in SHALL be carried through an L-1 stage delay line; rom_data_in SHALL be delayed PAL_LAT cycles for transparency check.
REQ-019 hit_out SHALL be 1 only if delayed footprint=1, delayed enable=1 and delayed index != TRANSPARENT_IDX; pixel_out=pal_rgb_in when hit_out=1, else 12'h000.
REQ-020 pos_valid_in=1 SHALL load pending registers and set pos_pending_out; later pos_valid_in before frame start overwrites pending.
REQ-021 Frame start = hcount_in==0 && vcount_in==0; if pending, active SHALL take pending value and pos_pending_out SHALL clear on next edge.
REQ-022 pos_valid_in coincident with frame start SHALL load active directly; pos_pending_out stays 0.
REQ-023 Active position SHALL never change outside frame start (no tearing).

Reset
REQ-024 rst_in=1 at an edge SHALL clear pixel_out, hit_out, pos_pending_out, rom_addr_out, all delay lines, pending and active position (0,0) on that edge, mid-frame included.
REQ-025 First valid pixel_out after reset release SHALL appear L cycles after first sampled raster position.

Configuration
REQ-026 Macro SPRITE_MIRROR_EN SHALL add input mirror_in (1): sampled with pos_valid_in, applied at frame start with position; when active, col=WIDTH-1-((hcount_in-xa)>>SCALE_LOG2).
REQ-027 Without SPRITE_MIRROR_EN, mirror_in SHALL be absent and columns never flipped.

Verification (WIDTH=4, HEIGHT=2, SCALE_LOG2=0, ROM_LAT=PAL_LAT=2, L=6)
REQ-028 Reset, pos_valid_in with x=10,y=5 at vcount=100 -> pos_pending_out=1 until frame start, hit_out=0 at (10,5) this frame, hit next frame.
REQ-029 Active (10,5), raster (12,6), rom_data=8'h05, pal=12'hF80 -> rom_addr_out=6 one cycle later, pixel_out=12'hF80, hit_out=1 six cycles after sample.
REQ-030 rom_data_in=TRANSPARENT_IDX (8'h00) in footprint -> hit_out=0, pixel_out=12'h000; enable_in=0 -> same.
REQ-031 SCALE_LOG2=1, x=10 -> hcount 10 and 11 both give col 0; hcount 17 col 3; hcount 18 outside.
REQ-032 x=638 -> hcount 638,639 hit; hcount 0,1 of next line no hit (no wrap).
REQ-033 rst_in pulse mid-sprite -> pixel_out=0, hit_out=0 next edge; active position (0,0); with SPRITE_MIRROR_EN, mirror_in=1 at (12,6) -> rom_addr_out=5.
